// File: rtl/instr_aligner.sv
// instr_aligner: IF-side alignment stage for an RV32IC pipeline.
// Accepts in-order 32-bit fetch words, keeps up to three halfwords in a
// small shift buffer, and presents one 16- or 32-bit instruction per
// handshake together with its PC. Handles 32-bit instructions straddling
// a word boundary and redirects to halfword-aligned targets.
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    output logic        fetch_ready_o,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,

    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o
);

    // Halfword-aligned start PC; bit 1 decides whether the first fetched
    // word's low half is skipped.
    localparam logic [31:0] START_PC = RESET_PC & ~32'h1;

    // Buffer state: slot0 = buf[15:0] (oldest), slot1 = [31:16], slot2 = [47:32].
    logic [47:0] buf_q,     buf_d;
    logic [1:0]  cnt_q,     cnt_d;
    logic [31:0] pc_q,      pc_d;
    logic        skip_lo_q, skip_lo_d;

    // Decode / handshake helpers.
    logic        comp;
    logic        valid;
    logic        accept;
    logic        consume;
    logic [47:0] rem_buf;
    logic [1:0]  rem_cnt;

    // Output decode straight from registers: nothing on the fetch side can
    // reach instr_valid_o combinationally.
    always_comb begin
        comp  = (buf_q[1:0] != 2'b11);
        valid = ((cnt_q != 2'd0) && comp) || (cnt_q >= 2'd2);

        instr_valid_o      = valid;
        instr_compressed_o = valid && comp;
        instr_pc_o         = pc_q;
        if (!valid) begin
            instr_o = 32'h0;
        end else if (comp) begin
            instr_o = {16'h0000, buf_q[15:0]};
        end else begin
            instr_o = buf_q[31:0];
        end

        // Only backpressure: no room for a full word once two slots are held.
        fetch_ready_o = (cnt_q <= 2'd1) && !redirect_i;
        accept        = fetch_valid_i && fetch_ready_o;
        consume       = valid && instr_ready_i && !redirect_i;
    end

    // Next-state: consume first, then append the accepted word behind the
    // remainder; redirect overrides both.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        skip_lo_d = skip_lo_q;
        rem_buf   = buf_q;
        rem_cnt   = cnt_q;

        // Drop the consumed instruction and shift the rest down to slot0.
        if (consume) begin
            if (comp) begin
                rem_buf = {16'h0000, buf_q[47:16]};
                rem_cnt = cnt_q - 2'd1;
                pc_d    = pc_q + 32'd2;
            end else begin
                rem_buf = {32'h0000_0000, buf_q[47:32]};
                rem_cnt = cnt_q - 2'd2;
                pc_d    = pc_q + 32'd4;
            end
        end

        buf_d = rem_buf;
        cnt_d = rem_cnt;

        // Accept only happens with cnt<=1, so rem_cnt<=1 here and the
        // appended halfwords always fit in the three slots.
        if (accept) begin
            if (skip_lo_q) begin
                case (rem_cnt)
                    2'd0:    buf_d[15:0]  = fetch_data_i[31:16];
                    2'd1:    buf_d[31:16] = fetch_data_i[31:16];
                    default: buf_d[47:32] = fetch_data_i[31:16];
                endcase
                cnt_d     = rem_cnt + 2'd1;
                skip_lo_d = 1'b0;
            end else begin
                case (rem_cnt)
                    2'd0:    buf_d[31:0]  = fetch_data_i;
                    default: buf_d[47:16] = fetch_data_i;
                endcase
                cnt_d = rem_cnt + 2'd2;
            end
        end

        // Redirect wins: flush, restart at the new target, drop any word
        // presented this cycle.
        if (redirect_i) begin
            buf_d     = 48'h0;
            cnt_d     = 2'd0;
            pc_d      = redirect_pc_i & ~32'h1;
            skip_lo_d = redirect_pc_i[1];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the buffer is only three halfwords, so it is reset too;
            // that keeps instr_o free of X even though cnt alone gates validity.
            buf_q     <= 48'h0;
            cnt_q     <= 2'd0;
            pc_q      <= START_PC;
            skip_lo_q <= RESET_PC[1];
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others.
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: table-driven directed bench for instr_aligner, plus
// hand-written sequences for stall/drain and asynchronous reset.
module tb_instr_aligner;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_comp;

    int checks = 0;
    int errors = 0;

    instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_valid_i      (fetch_valid),
        .fetch_data_i       (fetch_data),
        .fetch_ready_o      (fetch_ready),
        .redirect_i         (redirect),
        .redirect_pc_i      (redirect_pc),
        .instr_valid_o      (instr_valid),
        .instr_ready_i      (instr_ready),
        .instr_o            (instr),
        .instr_pc_o         (instr_pc),
        .instr_compressed_o (instr_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected during that cycle.
    typedef struct {
        logic        fv;
        logic [31:0] fd;
        logic        rd;
        logic [31:0] rpc;
        logic        ir;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic        ec;
        logic        efr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fv, logic [31:0] fd, logic rd, logic [31:0] rpc,
                                logic ir, logic ev, logic [31:0] ei, logic [31:0] epc,
                                logic ec, logic efr);
        vec_t v;
        v.fv = fv; v.fd = fd; v.rd = rd; v.rpc = rpc; v.ir = ir;
        v.ev = ev; v.ei = ei; v.epc = epc; v.ec = ec; v.efr = efr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] ei,
                              input logic [31:0] epc, input logic ec, input logic efr);
        check({tag, " valid"}, {31'h0, instr_valid}, {31'h0, ev});
        check({tag, " instr"}, instr, ei);
        check({tag, " pc"}, instr_pc, epc);
        check({tag, " comp"}, {31'h0, instr_comp}, {31'h0, ec});
        check({tag, " fready"}, {31'h0, fetch_ready}, {31'h0, efr});
    endtask

    // Drive inputs at the falling edge; outputs settle #1 later, well before
    // the next rising edge.
    task automatic drive(input logic fv, input logic [31:0] fd, input logic rd,
                         input logic [31:0] rpc, input logic ir);
        @(negedge clk);
        fetch_valid = fv;
        fetch_data  = fd;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = ir;
        #1;
    endtask

    initial begin
        // Reset state, checked before the first clock edge.
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_data = 32'h0; redirect = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b1;
        #1;
        check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        //          fv  fd            rd  rpc           ir   ev  instr         pc            c   fr
        // T1: single 32-bit instruction
        vecs.push_back(mk(1, 32'h00A00093, 0, 32'h0,     1,   0, 32'h0,        32'h000,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00A00093, 32'h000,      0,  0));
        // T2: two compressed instructions in one word
        vecs.push_back(mk(1, 32'h45050505, 0, 32'h0,     1,   0, 32'h0,        32'h004,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00000505, 32'h004,      1,  0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00004505, 32'h006,      1,  1));
        // T3: straddling 32-bit instruction
        vecs.push_back(mk(1, 32'h00934505, 0, 32'h0,     1,   0, 32'h0,        32'h008,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00004505, 32'h008,      1,  0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   0, 32'h0,        32'h00A,      0,  1));
        vecs.push_back(mk(1, 32'h450500A0, 0, 32'h0,     1,   0, 32'h0,        32'h00A,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00A00093, 32'h00A,      0,  0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00004505, 32'h00E,      1,  1));
        // T4: redirect to 0x102 while two stale instructions are buffered
        vecs.push_back(mk(1, 32'h05050505, 0, 32'h0,     1,   0, 32'h0,        32'h010,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     0,   1, 32'h00000505, 32'h010,      1,  0));
        vecs.push_back(mk(0, 32'h0,        1, 32'h102,   1,   1, 32'h00000505, 32'h010,      1,  0));
        vecs.push_back(mk(1, 32'h00014505, 0, 32'h0,     1,   0, 32'h0,        32'h102,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00000001, 32'h102,      1,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   0, 32'h0,        32'h104,      0,  1));
        // T6a: redirect with a word presented -> word dropped
        vecs.push_back(mk(1, 32'h45054505, 1, 32'h200,   1,   0, 32'h0,        32'h104,      0,  0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   0, 32'h0,        32'h200,      0,  1));
        // Redirect while an instruction is valid and ready -> no consume
        vecs.push_back(mk(1, 32'h45054505, 0, 32'h0,     1,   0, 32'h0,        32'h200,      0,  1));
        vecs.push_back(mk(0, 32'h0,        1, 32'h300,   1,   1, 32'h00004505, 32'h200,      1,  0));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   0, 32'h0,        32'h300,      0,  1));
        // Back-to-back redirects: last wins, odd-halfword target skips low half
        vecs.push_back(mk(0, 32'h0,        1, 32'h400,   1,   0, 32'h0,        32'h300,      0,  0));
        vecs.push_back(mk(0, 32'h0,        1, 32'h407,   1,   0, 32'h0,        32'h400,      0,  0));
        vecs.push_back(mk(1, 32'h12345678, 0, 32'h0,     1,   0, 32'h0,        32'h406,      0,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   1, 32'h00001234, 32'h406,      1,  1));
        vecs.push_back(mk(0, 32'h0,        0, 32'h0,     1,   0, 32'h0,        32'h408,      0,  1));

        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].fd, vecs[i].rd, vecs[i].rpc, vecs[i].ir);
            check_outs($sformatf("row%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].epc,
                       vecs[i].ec, vecs[i].efr);
        end

        // T5: fill to cnt=3 with a straddle, stall 5 cycles, then drain.
        drive(0, 32'h0, 1, 32'h500, 1);
        drive(1, 32'h00934505, 0, 32'h0, 1);
        check_outs("t5 empty", 1'b0, 32'h0, 32'h500, 1'b0, 1'b1);
        drive(0, 32'h0, 0, 32'h0, 1);
        check_outs("t5 c0", 1'b1, 32'h00004505, 32'h500, 1'b1, 1'b0);
        drive(1, 32'h450500A0, 0, 32'h0, 0);
        check_outs("t5 straddle", 1'b0, 32'h0, 32'h502, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) begin
            drive(1, 32'hFFFFFFFF, 0, 32'h0, 0);
            check_outs($sformatf("t5 stall%0d", s), 1'b1, 32'h00A00093, 32'h502, 1'b0, 1'b0);
        end
        drive(0, 32'h0, 0, 32'h0, 1);
        check_outs("t5 drain0", 1'b1, 32'h00A00093, 32'h502, 1'b0, 1'b0);
        drive(0, 32'h0, 0, 32'h0, 1);
        check_outs("t5 drain1", 1'b1, 32'h00004505, 32'h506, 1'b1, 1'b1);
        drive(0, 32'h0, 0, 32'h0, 1);
        check_outs("t5 empty2", 1'b0, 32'h0, 32'h508, 1'b0, 1'b1);

        // T6b: asynchronous reset mid-stream takes effect without a clock edge.
        drive(1, 32'h00A00093, 0, 32'h0, 0);
        drive(0, 32'h0, 0, 32'h0, 0);
        check_outs("t6 held", 1'b1, 32'h00A00093, 32'h508, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_outs("t6 async rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h45054505, 0, 32'h0, 1);
        check_outs("t6 post rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(0, 32'h0, 0, 32'h0, 1);
        check_outs("t6 first", 1'b1, 32'h00004505, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
